// File: rtl/adc_mux_arbiter.sv
// Shares the single external ADC between QCW over-current detect and boost current sense,
// sequencing mux switch-overs with settle waits and qualifying samples per consumer.
module adc_mux_arbiter #(
  parameter int unsigned SETTLE_CYCLES  = 24,
  parameter int unsigned POST_HOLD      = 240,
  parameter int unsigned ACTIVE_TIMEOUT = 2400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       qcw_req,
  input  logic       qcw_active,
  input  logic [9:0] adc_data,
  input  logic       clear_err,
  output logic       adc_mux,
  output logic       qcw_go,
  output logic       boost_grant,
  output logic [9:0] adc_data_q,
  output logic       ocd_valid,
  output logic       il_valid,
  output logic       timeout_err,
  output logic [15:0] switch_count
);

  localparam logic [15:0] SettleLast  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] HoldLast    = 16'(POST_HOLD - 1);
  localparam logic [15:0] TimeoutLast = 16'(ACTIVE_TIMEOUT - 1);

  typedef enum logic [2:0] {StBoost, StSetOcd, StOcd, StHold, StSetBst} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        seen_q, seen_d;
  logic        go_d, terr_set;
  logic        mux_d, grant_d, ocd_valid_d, il_valid_d, timeout_err_d;
  logic [15:0] switch_count_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    seen_d   = seen_q;
    go_d     = 1'b0;
    terr_set = 1'b0;
    unique case (state_q)
      StBoost: begin
        if (qcw_req) state_d = StSetOcd;
      end
      StSetOcd: begin
        if (cnt_q == SettleLast) begin
          state_d = StOcd;
          go_d    = 1'b1;
          seen_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StOcd: begin
        // Once the driver has started, the timeout no longer applies; wait for it to finish.
        if (seen_q || qcw_active) begin
          seen_d = 1'b1;
          cnt_d  = cnt_q;
          if (seen_q && !qcw_active) begin
            state_d = StHold;
            cnt_d   = '0;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d  = StSetBst;
          terr_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StHold: begin
        // Mux already on OCD, so a new request fires without resettling.
        if (qcw_req) begin
          state_d = StOcd;
          go_d    = 1'b1;
          seen_d  = 1'b0;
        end else if (cnt_q == HoldLast) begin
          state_d = StSetBst;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StSetBst: begin
        if (qcw_req) begin
          state_d = StSetOcd;
        end else if (cnt_q == SettleLast) begin
          state_d = StBoost;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StBoost;
    endcase
  end

  // Output flops decode the next state so they change on the same edge as the state.
  always_comb begin
    mux_d          = (state_d == StSetOcd) || (state_d == StOcd) || (state_d == StHold);
    grant_d        = (state_d == StBoost);
    switch_count_d = switch_count;
    if ((mux_d != adc_mux) && (switch_count != 16'hFFFF)) switch_count_d = switch_count + 16'd1;
    ocd_valid_d    = (state_q == StOcd) || (state_q == StHold);
    il_valid_d     = (state_q == StBoost) && boost_grant;
    timeout_err_d  = terr_set | (timeout_err & ~clear_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StBoost;
      cnt_q        <= '0;
      seen_q       <= 1'b0;
      adc_mux      <= 1'b0;
      qcw_go       <= 1'b0;
      boost_grant  <= 1'b0;
      adc_data_q   <= '0;
      ocd_valid    <= 1'b0;
      il_valid     <= 1'b0;
      timeout_err  <= 1'b0;
      switch_count <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      adc_mux      <= mux_d;
      qcw_go       <= go_d;
      boost_grant  <= grant_d;
      adc_data_q   <= adc_data;
      ocd_valid    <= ocd_valid_d;
      il_valid     <= il_valid_d;
      timeout_err  <= timeout_err_d;
      switch_count <= switch_count_d;
    end
  end

endmodule
